flu_qdr_ctrl: RTL
=================

Name: flu_qdr_ctrl

Overview:
- Ring-buffer controller for the QDR memory behind the FLU QDR adapter, single QDR_CLK domain.
- Accepts FLU word-write requests from the write side and assigns each a QDR write address.
- Schedules QDR read commands in FIFO order, limited by free space (credits) in the read-side output FIFO.
- Tracks occupancy, outstanding reads and protocol errors.

Parameters:
- ADDR_WIDTH, 20, QDR word address width; buffer capacity = 2^ADDR_WIDTH words.
- OUT_CREDITS, 64, depth of the downstream output FIFO; maximum reads that may be issued but not yet taken.
- CNT_WIDTH, 8, width of credit/outstanding counters; must hold OUT_CREDITS.

Ports:
- QDR_CLK  in  1  clock
- QDR_RST  in  1  asynchronous reset, active-high
- CAL_DONE  in  1  QDR calibration complete
- IN_VALID  in  1  write side offers one word
- IN_READY  out  1  word accepted when IN_VALID & IN_READY
- QDR_WR_EN  out  1  QDR write command
- QDR_WR_ADDR  out  ADDR_WIDTH  QDR write address
- QDR_RD_EN  out  1  QDR read command
- QDR_RD_ADDR  out  ADDR_WIDTH  QDR read address
- QDR_RD_VALID  in  1  read data returned from QDR
- OUT_TAKE  in  1  downstream popped one word from the output FIFO (returns one credit)
- USED  out  ADDR_WIDTH+1  words stored in QDR and not yet read-issued
- EMPTY  out  1  USED == 0
- FULL  out  1  USED == 2^ADDR_WIDTH
- ERR  out  1  sticky protocol error

Behaviour:
- Reset: FSM enters INIT. Pointers wptr and rptr are cleared; each is ADDR_WIDTH+1 bits including a wrap bit.
- Reset values: credits = OUT_CREDITS, outstanding = 0, ERR = 0, IN_READY = 0, QDR_WR_EN = 0, QDR_RD_EN = 0, all addresses 0, USED = 0, EMPTY = 1, FULL = 0.
- Asynchronous reset mid-operation drops all state immediately. Commands in flight at the QDR are discarded by the system.
- FSM states:
  - INIT: waits for CAL_DONE = 1, then goes to RUN on the next edge.
  - RUN: normal operation. CAL_DONE = 0 returns the FSM to INIT. Pointers and counters are held, and no new commands are issued in INIT.
- IN_READY = RUN & ~FULL. It is combinational from registered state and is independent of IN_VALID.
- Write path (latency 1 from accept):
  - On accept, QDR_WR_EN = 1 in the next cycle with QDR_WR_ADDR = wptr[ADDR_WIDTH-1:0].
  - wptr increments modulo 2^(ADDR_WIDTH+1).
- Read issue is allowed in a cycle when RUN & USED > 0 & credits > 0, all evaluated on registered values.
- Read path (latency 1 from issue):
  - QDR_RD_EN = 1 in the next cycle with QDR_RD_ADDR = rptr[ADDR_WIDTH-1:0].
  - rptr increments; credits decrement; outstanding increments.
  - At most one read and one write per cycle.
- USED = wptr - rptr, modulo 2^(ADDR_WIDTH+1).
  - FULL when the pointers' low bits are equal and the wrap bits differ.
  - EMPTY when the pointers are fully equal.
  - A simultaneous accept and read issue leaves USED unchanged.
- Write-to-read ordering: a word accepted in cycle N becomes readable at the earliest in cycle N+1. Its RD command therefore trails its WR command by at least one cycle.
- Credits:
  - OUT_TAKE increments credits and a read issue decrements them. Both in the same cycle leave credits unchanged.
  - OUT_TAKE while credits == OUT_CREDITS sets ERR, and credits saturate.
- Outstanding:
  - QDR_RD_EN increments outstanding and QDR_RD_VALID decrements it. Both in the same cycle leave it unchanged.
  - QDR_RD_VALID while outstanding == 0 sets ERR, and the counter stays at 0.
- ERR is sticky until QDR_RST.
- Address wrap: 2^ADDR_WIDTH - 1 is followed by 0, and the wrap bit toggles.

Test Plan:
- Reset, CAL_DONE = 0, IN_VALID = 1 for 10 cycles -> IN_READY = 0, no WR/RD commands. Raise CAL_DONE -> IN_READY = 1 two edges later.
- ADDR_WIDTH = 4, OUT_CREDITS = 64, OUT_TAKE pulsed each read:
  - 16 words written back-to-back with reads blocked -> WR_ADDR 0..15, FULL = 1, USED = 16, IN_READY = 0.
  - Then unblock -> RD_ADDR 0..15 in order, EMPTY = 1 at end.
- OUT_CREDITS = 4, 10 words stored, OUT_TAKE = 0 -> exactly 4 RD commands (addr 0..3) then stall. One OUT_TAKE -> one RD at addr 4.
- Continuous write and read with ADDR_WIDTH = 4 for 40 words -> addresses wrap 15 -> 0 twice, USED never exceeds 16, read order equals write order.
- QDR_RD_VALID pulse with no read outstanding -> ERR = 1 next cycle and remains 1. QDR_RST -> ERR = 0.
- Drop CAL_DONE with USED = 5 -> commands stop, USED holds 5. Restore CAL_DONE -> reads resume at the held rptr.

Source files
------------

// File: rtl/flu_qdr_ctrl.sv
// Ring-buffer controller for the FLU QDR adapter: assigns write addresses, schedules
// FIFO-ordered reads against output-FIFO credits, tracks occupancy and protocol errors.
module flu_qdr_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 20,
  parameter int unsigned OUT_CREDITS = 64,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                  QDR_CLK,
  input  logic                  QDR_RST,
  input  logic                  CAL_DONE,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic                  QDR_WR_EN,
  output logic [ADDR_WIDTH-1:0] QDR_WR_ADDR,
  output logic                  QDR_RD_EN,
  output logic [ADDR_WIDTH-1:0] QDR_RD_ADDR,
  input  logic                  QDR_RD_VALID,
  input  logic                  OUT_TAKE,
  output logic [ADDR_WIDTH:0]   USED,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic                  ERR
);

  localparam int unsigned PTR_WIDTH = ADDR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CRED_MAX = CNT_WIDTH'(OUT_CREDITS);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_e;

  state_e                 state_q;
  logic                   cal_q;
  logic [PTR_WIDTH-1:0]   wptr_q, wptr_d;
  logic [PTR_WIDTH-1:0]   rptr_q, rptr_d;
  logic [CNT_WIDTH-1:0]   credits_q, credits_d;
  logic [CNT_WIDTH-1:0]   outst_q, outst_d;
  logic                   err_q, err_d;
  logic                   wr_en_q;
  logic [ADDR_WIDTH-1:0]  wr_addr_q;
  logic                   rd_en_q;
  logic [ADDR_WIDTH-1:0]  rd_addr_q;

  logic run_c, full_c, empty_c, accept_c, issue_c;
  logic take_ok_c, dec_ok_c;

  assign run_c   = (state_q == S_RUN);
  assign empty_c = (wptr_q == rptr_q);
  // Full: same slot, opposite lap.
  assign full_c  = (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]) &&
                   (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]);

  assign IN_READY = run_c & ~full_c;
  assign accept_c = IN_VALID & IN_READY;
  assign issue_c  = run_c & ~empty_c & (credits_q != '0);

  assign take_ok_c = OUT_TAKE & (credits_q != CRED_MAX);
  assign dec_ok_c  = QDR_RD_VALID & (outst_q != '0);

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    credits_d = credits_q;
    outst_d   = outst_q;
    err_d     = err_q;

    if (accept_c) wptr_d = wptr_q + PTR_WIDTH'(1);
    if (issue_c)  rptr_d = rptr_q + PTR_WIDTH'(1);

    // Saturated returns are dropped and flagged.
    case ({take_ok_c, issue_c})
      2'b10:   credits_d = credits_q + CNT_WIDTH'(1);
      2'b01:   credits_d = credits_q - CNT_WIDTH'(1);
      default: credits_d = credits_q;
    endcase

    case ({rd_en_q, dec_ok_c})
      2'b10:   outst_d = outst_q + CNT_WIDTH'(1);
      2'b01:   outst_d = outst_q - CNT_WIDTH'(1);
      default: outst_d = outst_q;
    endcase

    if ((OUT_TAKE && (credits_q == CRED_MAX)) || (QDR_RD_VALID && (outst_q == '0)))
      err_d = 1'b1;
  end

  // Entry into RUN waits one registered CAL_DONE cycle; loss of CAL_DONE exits at once.
  always_ff @(posedge QDR_CLK or posedge QDR_RST) begin
    if (QDR_RST) begin
      state_q   <= S_INIT;
      cal_q     <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      credits_q <= CRED_MAX;
      outst_q   <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      cal_q <= CAL_DONE;
      case (state_q)
        S_INIT:  if (cal_q && CAL_DONE) state_q <= S_RUN;
        S_RUN:   if (!CAL_DONE)         state_q <= S_INIT;
        default:                        state_q <= S_INIT;
      endcase

      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      credits_q <= credits_d;
      outst_q   <= outst_d;
      err_q     <= err_d;

      wr_en_q <= accept_c;
      if (accept_c) wr_addr_q <= wptr_q[ADDR_WIDTH-1:0];
      rd_en_q <= issue_c;
      if (issue_c)  rd_addr_q <= rptr_q[ADDR_WIDTH-1:0];
    end
  end

  assign QDR_WR_EN   = wr_en_q;
  assign QDR_WR_ADDR = wr_addr_q;
  assign QDR_RD_EN   = rd_en_q;
  assign QDR_RD_ADDR = rd_addr_q;
  assign USED        = wptr_q - rptr_q;
  assign EMPTY       = empty_c;
  assign FULL        = full_c;
  assign ERR         = err_q;

endmodule
